// File: rtl/reg_file_2r1w.sv
// Two-read, one-write register file: writes on the rising edge, reads latched on the falling edge.
// Define REG_FILE_R0_ZERO_EN to hardwire register 0 to zero.
module reg_file_2r1w #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [WIDTH-1:0]  write_data,
  input  logic              read_enable_a,
  input  logic [ADDR_W-1:0] read_addr_a,
  output logic [WIDTH-1:0]  read_data_a,
  input  logic              read_enable_b,
  input  logic [ADDR_W-1:0] read_addr_b,
  output logic [WIDTH-1:0]  read_data_b,
  output logic              addr_err
);

`ifdef REG_FILE_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  // A power-of-two depth leaves no unused addresses, so every index is in range.
  localparam bit              POW2    = (DEPTH == (1 << ADDR_W));
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return POW2 || ({1'b0, addr} < DEPTH_L);
  endfunction

  genvar gi;

  logic [WIDTH-1:0]  regs_view [DEPTH];
  logic              rd_en_in  [2];
  logic [ADDR_W-1:0] rd_addr_in[2];
  logic              rd_en_q   [2];
  logic [WIDTH-1:0]  rd_data_q [2];

  assign rd_en_in[0]   = read_enable_a;
  assign rd_en_in[1]   = read_enable_b;
  assign rd_addr_in[0] = read_addr_a;
  assign rd_addr_in[1] = read_addr_b;

  for (gi = 0; gi < DEPTH; gi++) begin : g_reg
    logic [WIDTH-1:0] data_reg;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        data_reg <= '0;
      end else if (write_enable && (write_addr == ADDR_W'(gi)) && !(R0_ZERO && gi == 0)) begin
        data_reg <= write_data;
      end
    end

    assign regs_view[gi] = data_reg;
  end

  // Falling-edge latch: a read sees the write made at the rising edge of the same cycle.
  for (gi = 0; gi < 2; gi++) begin : g_rd
    logic             en_reg;
    logic [WIDTH-1:0] data_reg;

    always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
        en_reg   <= 1'b0;
        data_reg <= '0;
      end else if (rd_en_in[gi]) begin
        en_reg   <= 1'b1;
        data_reg <= in_range(rd_addr_in[gi]) ? regs_view[rd_addr_in[gi]] : '0;
      end else begin
        en_reg   <= 1'b0;
      end
    end

    assign rd_en_q[gi]   = en_reg;
    assign rd_data_q[gi] = data_reg;
  end

  assign read_data_a = rd_en_q[0] ? rd_data_q[0] : {WIDTH{1'bz}};
  assign read_data_b = rd_en_q[1] ? rd_data_q[1] : {WIDTH{1'bz}};

  logic wr_oob_reg;
  logic addr_err_reg;
  logic addr_err_next;

  // Holds the rising-edge write's range result until the falling edge folds it into addr_err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_oob_reg <= 1'b0;
    end else if (write_enable && !in_range(write_addr)) begin
      wr_oob_reg <= 1'b1;
    end else begin
      wr_oob_reg <= 1'b0;
    end
  end

  always_comb begin
    addr_err_next = wr_oob_reg;
    for (int p = 0; p < 2; p++) begin
      if (rd_en_in[p] && !in_range(rd_addr_in[p])) begin
        addr_err_next = 1'b1;
      end
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      addr_err_reg <= 1'b0;
    end else begin
      addr_err_reg <= addr_err_next;
    end
  end

  assign addr_err = addr_err_reg;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Scoreboard bench for reg_file_2r1w: DEPTH=8 and DEPTH=6 instances share one stimulus stream,
// each checked against its own array model of the register file.
module tb_reg_file_2r1w;

`ifdef REG_FILE_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [2:0]  wa;
  logic [15:0] wd;
  logic        rea;
  logic [2:0]  raa;
  logic        reb;
  logic [2:0]  rab;
  wire  [15:0] rda8, rdb8, rda6, rdb6;
  wire         err8, err6;

  always #5 clk = ~clk;

  reg_file_2r1w #(.WIDTH(16), .DEPTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .write_enable(we), .write_addr(wa), .write_data(wd),
    .read_enable_a(rea), .read_addr_a(raa), .read_data_a(rda8),
    .read_enable_b(reb), .read_addr_b(rab), .read_data_b(rdb8),
    .addr_err(err8)
  );

  reg_file_2r1w #(.WIDTH(16), .DEPTH(6)) dut6 (
    .clk(clk), .rst(rst),
    .write_enable(we), .write_addr(wa), .write_data(wd),
    .read_enable_a(rea), .read_addr_a(raa), .read_data_a(rda6),
    .read_enable_b(reb), .read_addr_b(rab), .read_data_b(rdb6),
    .addr_err(err6)
  );

  typedef struct {
    int              cyc;
    logic            ena;
    logic            enb;
    logic [1:0][15:0] a;
    logic [1:0][15:0] b;
    logic [1:0]      err;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model [2][8];
  int          cyc     = 0;
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic int depth_of(input int k);
    return (k == 0) ? 8 : 6;
  endfunction

  function automatic logic [15:0] model_read(input int k, input logic [2:0] addr);
    if (int'(addr) >= depth_of(k)) return 16'h0000;
    return model[k][addr];
  endfunction

  // A disabled port must float; two-state simulators resolve the undriven bus to 0.
  task automatic chk_port(input string name, input int c, input logic en,
                          input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (!en) begin
      if (!(act === 16'hzzzz || act === 16'h0000)) begin
        n_fail++;
        $display("FAIL %s cyc %0d: got %h, expected high-Z", name, c, act);
      end
    end else if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc %0d: got %h, expected %h", name, c, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input int c, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc %0d: got %b, expected %b", name, c, act, exp);
    end
  endtask

  // Drive one cycle's inputs and queue what the falling edge of that cycle must show.
  task automatic apply(input logic r, input logic w_en, input logic [2:0] w_a, input logic [15:0] w_d,
                       input logic a_en, input logic [2:0] a_a, input logic b_en, input logic [2:0] b_a);
    exp_t e;
    logic was_out_of_reset;
    was_out_of_reset = (rst === 1'b1);
    rst = r; we = w_en; wa = w_a; wd = w_d;
    rea = a_en; raa = a_a; reb = b_en; rab = b_a;
    cyc++;
    e.cyc = cyc;
    e.ena = r && a_en;
    e.enb = r && b_en;
    for (int k = 0; k < 2; k++) begin
      if (!r) begin
        for (int i = 0; i < 8; i++) model[k][i] = 16'h0000;
        e.a[k]   = 16'h0000;
        e.b[k]   = 16'h0000;
        e.err[k] = 1'b0;
      end else begin
        if (w_en && int'(w_a) < depth_of(k) && !(R0Z && w_a == 3'd0)) model[k][w_a] = w_d;
        e.a[k]   = model_read(k, a_a);
        e.b[k]   = model_read(k, b_a);
        e.err[k] = (w_en && int'(w_a) >= depth_of(k)) || (a_en && int'(a_a) >= depth_of(k))
                || (b_en && int'(b_a) >= depth_of(k));
      end
    end
    exp_q.push_back(e);
    if (was_out_of_reset && !r) begin
      // No clock edge has passed yet, so only an asynchronous reset can have cleared the outputs.
      #1;
      chk_port("async_rst_a8", cyc, 1'b0, rda8, 16'h0000);
      chk_port("async_rst_b8", cyc, 1'b0, rdb8, 16'h0000);
      chk_port("async_rst_a6", cyc, 1'b0, rda6, 16'h0000);
      chk_bit("async_rst_err6", cyc, err6, 1'b0);
    end
  endtask

  task automatic cycle(input logic r, input logic w_en, input logic [2:0] w_a, input logic [15:0] w_d,
                       input logic a_en, input logic [2:0] a_a, input logic b_en, input logic [2:0] b_a);
    @(negedge clk);
    #2;
    apply(r, w_en, w_a, w_d, a_en, a_a, b_en, b_a);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("[TB] cyc %0d A8=%h B8=%h err8=%b A6=%h B6=%h err6=%b",
                 e.cyc, rda8, rdb8, err8, rda6, rdb6, err6);
        chk_port("rd_a_d8", e.cyc, e.ena, rda8, e.a[0]);
        chk_port("rd_b_d8", e.cyc, e.enb, rdb8, e.b[0]);
        chk_bit("err_d8", e.cyc, err8, e.err[0]);
        chk_port("rd_a_d6", e.cyc, e.ena, rda6, e.a[1]);
        chk_port("rd_b_d6", e.cyc, e.enb, rdb6, e.b[1]);
        chk_bit("err_d6", e.cyc, err6, e.err[1]);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    // Reset held for 1.2 periods with both ports disabled.
    apply(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd0);
    cycle(1'b1, 1'b1, 3'd2, 16'h123f, 1'b0, 3'd0, 1'b0, 3'd0);
    cycle(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 1'b0, 3'd0);
    // Same-cycle write and read, then drop port B.
    cycle(1'b1, 1'b1, 3'd7, 16'h78da, 1'b1, 3'd7, 1'b1, 3'd7);
    cycle(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd7, 1'b0, 3'd7);
    // Dual-port independence and address swap.
    cycle(1'b1, 1'b1, 3'd1, 16'h1111, 1'b0, 3'd0, 1'b0, 3'd0);
    cycle(1'b1, 1'b1, 3'd5, 16'h5555, 1'b0, 3'd0, 1'b0, 3'd0);
    cycle(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 1'b1, 3'd5);
    cycle(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 1'b1, 3'd1);
    // Load every register, then reset mid-operation with a write pending.
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 3'(i), 16'h4532, 1'b1, 3'(i), 1'b1, 3'(7 - i));
    cycle(1'b0, 1'b1, 3'd3, 16'hffff, 1'b1, 3'd3, 1'b1, 3'd4);
    cycle(1'b0, 1'b1, 3'd3, 16'hffff, 1'b1, 3'd3, 1'b1, 3'd4);
    cycle(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 1'b1, 3'd4);
    // Out-of-range accesses on the six-entry instance.
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 3'(i), 16'(16'h1000 + i), 1'b0, 3'd0, 1'b0, 3'd0);
    cycle(1'b1, 1'b1, 3'd6, 16'hbeef, 1'b0, 3'd0, 1'b0, 3'd0);
    cycle(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd7, 1'b0, 3'd0);
    cycle(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 1'b1, 3'd1);
    for (int i = 0; i < 8; i += 2) cycle(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'(i), 1'b1, 3'(i + 1));
    // Register 0 behaviour depends on REG_FILE_R0_ZERO_EN.
    cycle(1'b1, 1'b1, 3'd0, 16'h4532, 1'b0, 3'd0, 1'b0, 3'd0);
    cycle(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 1'b1, 3'd0);
    // Randomized traffic with occasional resets.
    for (int n = 0; n < 300; n++) begin
      cycle(1'($urandom_range(0, 99) >= 3),
            1'($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), 16'($urandom),
            1'($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)));
    end
    cycle(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd0);
    @(negedge clk);
    #3;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
Parametrised successor to the single-port lab register file: one write port and two independent read ports, with configurable width and depth. Writes are positive-edge triggered. Reads are negative-edge registered, so a read sees a write made in the same cycle. Read ports float to high-Z when disabled, so they can share a bus. Intended as the operand register file feeding the lab ALU datapath.

Parameters:
WIDTH, 16, data width in bits of every register and port.
DEPTH, 8, number of registers; need not be a power of two.
ADDR_W, $clog2(DEPTH) (minimum 1), address width in bits.

Ports:
clk  input  1  clock; writes on rising edge, reads on falling edge.
rst  input  1  asynchronous, active-low reset.
write_enable  input  1  write strobe.
write_addr  input  ADDR_W  write register index.
write_data  input  WIDTH  write value.
read_enable_a  input  1  port A read strobe.
read_addr_a  input  ADDR_W  port A register index.
read_data_a  output  WIDTH  port A data; high-Z when disabled.
read_enable_b  input  1  port B read strobe.
read_addr_b  input  ADDR_W  port B register index.
read_data_b  output  WIDTH  port B data; high-Z when disabled.
addr_err  output  1  registered out-of-range access flag.

Behaviour:
- Reset (rst=0), asynchronous:
  - all DEPTH registers cleared to 0;
  - both read enable latches cleared, so read_data_a and read_data_b go high-Z;
  - both read data latches cleared to 0;
  - addr_err cleared to 0.
  - Held while rst=0. Reset wins over any simultaneous write.
  - Deassertion takes effect at the next clock edge; no synchroniser inside the block.
- Write, rising clk:
  - if write_enable=1 and write_addr<DEPTH, the register at write_addr takes write_data;
  - if write_addr>=DEPTH, no register changes.
- Read, falling clk, per port P (A or B), independently:
  - the enable latch for P takes read_enable_P;
  - if read_enable_P=1 and read_addr_P<DEPTH, the data latch for P takes the addressed register;
  - if read_enable_P=1 and read_addr_P>=DEPTH, the data latch for P takes 0.
- Read output: read_data_P = data latch when the enable latch is 1, else all bits Z. Output changes only at a falling edge or on reset.
- Latency: a write at rising edge N is visible on a read port at the falling edge of the same cycle, half a period later. No bypass logic is needed.
- Both ports may read the same address, including the one being written, with identical results.
- addr_err:
  - updated at each falling edge;
  - set to 1 if, in the preceding half-cycle, any enabled access (write, read A or read B) used an address >= DEPTH;
  - otherwise set to 0.
  - When DEPTH is a power of two, addr_err is constant 0.
- Reset asserted mid-operation: registers are lost immediately. After release, reads return 0 until a register is rewritten.
- X/Z on any enable is treated as 0. Out-of-range index evaluation must not produce X on the outputs.

Optional Feature:
Macro REG_FILE_R0_ZERO_EN.
- Defined: register 0 is hardwired to zero. Writes to address 0 are discarded with no addr_err. Reads of address 0 return 0.
- Undefined: register 0 is an ordinary storage register.

Test Plan:
1. Reset with defaults: rst=0 for 1.2 periods, read_enable_a=read_enable_b=0 -> both read ports Z, addr_err=0; then write 16'h123f to reg 2 and read reg 2 on A -> A=16'h123f.
2. Same-cycle write/read: write 16'h78da to reg 7 while A and B both read reg 7 -> both ports 16'h78da at that cycle's falling edge. Drop read_enable_b -> B goes Z at the next falling edge while A holds 16'h78da.
3. Dual-port independence: reg 1=16'h1111, reg 5=16'h5555; A reads reg 1 and B reads reg 5 -> A=16'h1111, B=16'h5555. Swap addresses -> values swap on the next falling edge.
4. Mid-operation reset: regs 0..7 loaded with 16'h4532; assert rst for 2 periods while write_enable=1 with write_data=16'hffff -> enabled ports read 0 after release, and nothing is written during reset.
5. Non-power-of-two depth (DEPTH=6, ADDR_W=3): write 16'hbeef to addr 6 -> regs 0..5 unchanged, addr_err=1 at the falling edge. A reading addr 7 -> A=0, addr_err=1. Next clean cycle -> addr_err=0.
6. With REG_FILE_R0_ZERO_EN: write 16'h4532 to reg 0, then read reg 0 on both ports -> both 0. Without the macro -> both 16'h4532.
